video_cmd_queue: RTL and testbench
==================================

Name: video_cmd_queue

Overview:
Multi-channel command queue front-end for the video accelerator's data movers. It generalises the fixed two-queue source/destination command FIFOs to N_CH independent 64-bit command queues of parametrised depth. Commands are built from 32-bit register writes using explicit LO/HI addresses. The block adds per-channel status, overflow and sequence-error flags, flush, completion counters and a maskable interrupt. It sits between the AXI-Lite BRAM-style controller and the movers' valid/ready command inputs.

Parameters:
N_CH, 2, number of command channels (1..8)
DEPTH, 3, log2 of entries per channel queue (1..15)
CMD_WIDTH, 64, command word width (fixed 64, assembled as {HI,LO})

Ports:
aclk  in  1  clock; all logic on rising edge
rst  in  1  synchronous active-high reset
reg_en  in  1  register access strobe
reg_we  in  4  byte write enables; only 4'hF performs a write
reg_addr  in  12  byte address
reg_wdata  in  32  write data
reg_rdata  out  32  read data, valid one cycle after reg_en
cmd_data  out  N_CH*64  head entry per channel, channel c at [64c+63:64c]
cmd_valid  out  N_CH  channel queue non-empty
cmd_ready  in  N_CH  mover accepts head entry
cmd_done  in  N_CH  one-cycle completion pulse per channel
irq  out  1  |(irq_status & irq_en)

Behaviour:
- Reset is synchronous and active-high. On rst: queues empty, cmd_valid=0, reg_rdata=0, lo_pending=0, all flags 0, done counters 0, irq_en=0, irq_status=0, irq=0. A command being assembled is discarded.
- Per-channel register map at base 16*c:
  - +0 CMD_LO (W): stage the low word and set lo_pending.
  - +4 CMD_HI (W): if lo_pending, push {wdata, staged_lo} and clear lo_pending. Otherwise drop the write and set seq_err.
  - +8 STATUS (R): [15:0] count, [16] full, [17] empty, [18] overflow, [19] lo_pending, [20] seq_err. Writing it: bit18=1 clears overflow, bit20=1 clears seq_err, bit31=1 flushes the queue.
  - +12 DONE_CNT (R): [15:0] completions. Any write clears it.
- Global registers:
  - 0x100 IRQ_EN (RW, [N_CH-1:0]).
  - 0x104 IRQ_STATUS (R; write-1-to-clear).
  - Unmapped or out-of-range addresses read 0; writes to them are ignored.
- Reads: reg_rdata is registered from the address sampled on reg_en, so latency is 1 cycle. It holds its value when reg_en=0. A read returns pre-update state for the same cycle.
- Queue: first-word-fall-through. cmd_valid = !empty; cmd_data = head.
  - Pop occurs when cmd_valid & cmd_ready.
  - Push is accepted when !full, or when full and a pop happens in the same cycle.
  - A rejected push sets overflow sticky and leaves the queue and count unchanged.
  - Simultaneous push and pop: count unchanged, order preserved.
  - Pointers wrap modulo 2^DEPTH. count is DEPTH+1 bits, zero-extended, range 0..2^DEPTH.
- Flush: empties the queue and clears lo_pending in one cycle. Flush wins over a same-cycle pop. The mover must not rely on a head popped in the flush cycle.
- Done handling: a cmd_done[c] pulse increments DONE_CNT[c], saturating at 0xFFFF, and sets irq_status[c].
  - DONE_CNT clear and done pulse in the same cycle: result is 1.
  - IRQ_STATUS W1C and done pulse in the same cycle: the bit stays set.
- irq is registered: it reflects irq_status & irq_en one cycle after either changes.
- Partial-byte writes (reg_we != 4'hF) have no effect on any state.

Test Plan:
1. Ch0: write LO=0x11223344, then HI=0x55667788. Next cycle cmd_valid[0]=1 and cmd_data[63:0]=0x5566778811223344. STATUS reads count=1, empty=0.
2. Ch1 with DEPTH=3, cmd_ready=0: push 9 commands. STATUS reads count=8, full=1, overflow=1, and the 9th command is absent. Then raise cmd_ready: 8 pops come out in order, and empty=1 after the last.
3. Write HI with no prior LO on ch0. Nothing is pushed and STATUS[20]=1. Write STATUS with bit20=1, then read back: seq_err=0.
4. Fill ch0 to full. In one cycle, push while cmd_ready[0]=1. Count stays 8, overflow=0, and the new entry appears last.
5. Set IRQ_EN=0x2 and pulse cmd_done[1] three times. DONE_CNT1=3, IRQ_STATUS=0x2, and irq=1 one cycle after the first pulse. W1C 0x2 in the same cycle as a 4th pulse: the bit stays set and the count is 4.
6. With 5 entries and lo_pending=1 on ch0, write STATUS bit31 while cmd_ready=1. Next cycle count=0, cmd_valid=0, lo_pending=0. Assert rst mid-assembly: every output returns to 0 on the next edge.

Source files
------------

// File: rtl/video_cmd_queue.sv
// Register-programmed multi-channel 64-bit command queues feeding the data movers.
// Commands are assembled from LO/HI register writes, buffered FWFT, and tracked with done counters and an IRQ.
module video_cmd_queue #(
  parameter int N_CH      = 2,
  parameter int DEPTH     = 3,
  parameter int CMD_WIDTH = 64
) (
  input  logic                      aclk,
  input  logic                      rst,
  input  logic                      reg_en,
  input  logic [3:0]                reg_we,
  input  logic [11:0]               reg_addr,
  input  logic [31:0]               reg_wdata,
  output logic [31:0]               reg_rdata,
  output logic [N_CH*CMD_WIDTH-1:0] cmd_data,
  output logic [N_CH-1:0]           cmd_valid,
  input  logic [N_CH-1:0]           cmd_ready,
  input  logic [N_CH-1:0]           cmd_done,
  output logic                      irq
);

  localparam int ENTRIES = 1 << DEPTH;
  localparam int CW      = DEPTH + 1;

  logic [CMD_WIDTH-1:0] mem_q [N_CH][ENTRIES];
  logic [DEPTH-1:0]     wptr_q [N_CH];
  logic [DEPTH-1:0]     wptr_d [N_CH];
  logic [DEPTH-1:0]     rptr_q [N_CH];
  logic [DEPTH-1:0]     rptr_d [N_CH];
  logic [CW-1:0]        count_q [N_CH];
  logic [CW-1:0]        count_d [N_CH];
  logic [31:0]          lo_q [N_CH];
  logic [31:0]          lo_d [N_CH];
  logic [15:0]          done_cnt_q [N_CH];
  logic [15:0]          done_cnt_d [N_CH];
  logic [N_CH-1:0]      lo_pend_q, lo_pend_d, ovf_q, ovf_d, seq_err_q, seq_err_d;
  logic [N_CH-1:0]      irq_en_q, irq_en_d, irq_st_q, irq_st_d;
  logic [N_CH-1:0]      wr_lo, wr_hi, wr_st, wr_dc, push_ok, pop, full, empty;
  logic                 irq_q, irq_d;
  logic [31:0]          rdata_q, rdata_d, read_val;
  logic                 wr_en;
  logic [1:0]           off;

  // Byte-lane-partial writes are treated as no access at all.
  assign wr_en = reg_en && (reg_we == 4'hF);
  assign off   = reg_addr[3:2];

  always_comb begin
    wr_lo = '0;
    wr_hi = '0;
    wr_st = '0;
    wr_dc = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (wr_en && (reg_addr[11:4] == 8'(c))) begin
        case (off)
          2'd0:    wr_lo[c] = 1'b1;
          2'd1:    wr_hi[c] = 1'b1;
          2'd2:    wr_st[c] = 1'b1;
          default: wr_dc[c] = 1'b1;
        endcase
      end
    end
  end

  always_comb begin
    lo_pend_d = lo_pend_q;
    ovf_d     = ovf_q;
    seq_err_d = seq_err_q;
    push_ok   = '0;
    pop       = '0;
    full      = '0;
    empty     = '0;
    for (int c = 0; c < N_CH; c++) begin
      wptr_d[c]     = wptr_q[c];
      rptr_d[c]     = rptr_q[c];
      count_d[c]    = count_q[c];
      lo_d[c]       = lo_q[c];
      done_cnt_d[c] = done_cnt_q[c];

      empty[c]   = (count_q[c] == '0);
      full[c]    = (count_q[c] == CW'(ENTRIES));
      pop[c]     = !empty[c] && cmd_ready[c];
      // A full queue still accepts when its head leaves in the same cycle.
      push_ok[c] = wr_hi[c] && lo_pend_q[c] && (!full[c] || pop[c]);

      if (wr_lo[c]) begin
        lo_d[c]      = reg_wdata;
        lo_pend_d[c] = 1'b1;
      end
      if (wr_hi[c]) begin
        lo_pend_d[c] = 1'b0;
        if (!lo_pend_q[c])    seq_err_d[c] = 1'b1;
        else if (!push_ok[c]) ovf_d[c]     = 1'b1;
      end
      if (wr_st[c] && reg_wdata[18]) ovf_d[c]     = 1'b0;
      if (wr_st[c] && reg_wdata[20]) seq_err_d[c] = 1'b0;

      if (wr_st[c] && reg_wdata[31]) begin
        wptr_d[c]    = '0;
        rptr_d[c]    = '0;
        count_d[c]   = '0;
        lo_pend_d[c] = 1'b0;
      end else begin
        if (push_ok[c]) wptr_d[c] = wptr_q[c] + DEPTH'(1);
        if (pop[c])     rptr_d[c] = rptr_q[c] + DEPTH'(1);
        if (push_ok[c] && !pop[c])      count_d[c] = count_q[c] + CW'(1);
        else if (!push_ok[c] && pop[c]) count_d[c] = count_q[c] - CW'(1);
      end

      // A clear coinciding with a completion leaves a count of one.
      if (wr_dc[c])
        done_cnt_d[c] = {15'd0, cmd_done[c]};
      else if (cmd_done[c] && (done_cnt_q[c] != 16'hFFFF))
        done_cnt_d[c] = done_cnt_q[c] + 16'd1;
    end

    irq_en_d = irq_en_q;
    if (wr_en && (reg_addr == 12'h100)) irq_en_d = reg_wdata[N_CH-1:0];
    irq_st_d = irq_st_q;
    if (wr_en && (reg_addr == 12'h104)) irq_st_d = irq_st_q & ~reg_wdata[N_CH-1:0];
    irq_st_d = irq_st_d | cmd_done;
    irq_d    = |(irq_st_q & irq_en_q);

    rdata_d = reg_en ? read_val : rdata_q;
  end

  always_comb begin
    read_val = '0;
    if (reg_addr == 12'h100)      read_val = 32'(irq_en_q);
    else if (reg_addr == 12'h104) read_val = 32'(irq_st_q);
    else begin
      for (int c = 0; c < N_CH; c++) begin
        if (reg_addr[11:4] == 8'(c)) begin
          if (off == 2'd2)
            read_val = {11'd0, seq_err_q[c], lo_pend_q[c], ovf_q[c], empty[c], full[c],
                        16'(count_q[c])};
          else if (off == 2'd3)
            read_val = {16'd0, done_cnt_q[c]};
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      lo_pend_q <= '0;
      ovf_q     <= '0;
      seq_err_q <= '0;
      irq_en_q  <= '0;
      irq_st_q  <= '0;
      irq_q     <= 1'b0;
      rdata_q   <= '0;
      for (int c = 0; c < N_CH; c++) begin
        wptr_q[c]     <= '0;
        rptr_q[c]     <= '0;
        count_q[c]    <= '0;
        lo_q[c]       <= '0;
        done_cnt_q[c] <= '0;
      end
    end else begin
      lo_pend_q <= lo_pend_d;
      ovf_q     <= ovf_d;
      seq_err_q <= seq_err_d;
      irq_en_q  <= irq_en_d;
      irq_st_q  <= irq_st_d;
      irq_q     <= irq_d;
      rdata_q   <= rdata_d;
      for (int c = 0; c < N_CH; c++) begin
        wptr_q[c]     <= wptr_d[c];
        rptr_q[c]     <= rptr_d[c];
        count_q[c]    <= count_d[c];
        lo_q[c]       <= lo_d[c];
        done_cnt_q[c] <= done_cnt_d[c];
      end
    end
  end

  always_ff @(posedge aclk) begin
    for (int c = 0; c < N_CH; c++) begin
      if (!rst && push_ok[c]) mem_q[c][wptr_q[c]] <= {reg_wdata, lo_q[c]};
    end
  end

  // Head data is forced to zero while empty so stale entries never leak out.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      cmd_data[c*CMD_WIDTH +: CMD_WIDTH] = empty[c] ? '0 : mem_q[c][rptr_q[c]];
    end
  end

  assign cmd_valid = ~empty;
  assign irq       = irq_q;
  assign reg_rdata = rdata_q;

endmodule

// File: tb/tb_video_cmd_queue.sv
// Directed bench for video_cmd_queue: a vector table for register/IRQ behaviour and
// hand-written sequences for overflow, full push+pop, flush and reset.
module tb_video_cmd_queue;

  logic         aclk = 1'b0;
  logic         rst;
  logic         reg_en;
  logic [3:0]   reg_we;
  logic [11:0]  reg_addr;
  logic [31:0]  reg_wdata;
  logic [31:0]  reg_rdata;
  logic [127:0] cmd_data;
  logic [1:0]   cmd_valid;
  logic [1:0]   cmd_ready;
  logic [1:0]   cmd_done;
  logic         irq;

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  video_cmd_queue #(.N_CH(2), .DEPTH(3), .CMD_WIDTH(64)) dut (
    .aclk(aclk), .rst(rst), .reg_en(reg_en), .reg_we(reg_we), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .cmd_data(cmd_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_done(cmd_done), .irq(irq)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic        en;
    logic [3:0]  we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [1:0]  rdy;
    logic [1:0]  done;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic [1:0]  exp_valid;
    logic        exp_irq;
    logic        chk_d0;
    logic [63:0] exp_d0;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic en, input logic [3:0] we, input logic [11:0] addr,
                              input logic [31:0] wdata, input logic [1:0] done,
                              input logic chk_rd, input logic [31:0] exp_rd,
                              input logic [1:0] exp_valid, input logic exp_irq,
                              input logic chk_d0, input logic [63:0] exp_d0);
    vec_t v;
    v.en = en; v.we = we; v.addr = addr; v.wdata = wdata; v.rdy = 2'b00; v.done = done;
    v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_valid = exp_valid; v.exp_irq = exp_irq;
    v.chk_d0 = chk_d0; v.exp_d0 = exp_d0;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic reg_access(input logic [3:0] we, input logic [11:0] a, input logic [31:0] d);
    @(negedge aclk);
    reg_en = 1'b1; reg_we = we; reg_addr = a; reg_wdata = d;
    @(posedge aclk);
    #1;
    reg_en = 1'b0; reg_we = 4'h0;
  endtask

  task automatic reg_wr(input logic [11:0] a, input logic [31:0] d);
    reg_access(4'hF, a, d);
  endtask

  task automatic rd_check(input string name, input logic [11:0] a, input logic [31:0] exp);
    reg_access(4'h0, a, 32'h0);
    check(name, 64'(reg_rdata), 64'(exp));
  endtask

  task automatic push_cmd(input int ch, input logic [31:0] lo, input logic [31:0] hi,
                          input bit accept);
    reg_wr(12'(16 * ch), lo);
    reg_wr(12'(16 * ch + 4), hi);
    if (accept) exp_q.push_back({hi, lo});
  endtask

  task automatic drain(input int ch, input int n, input string name);
    logic [63:0] e;
    @(negedge aclk);
    cmd_ready[ch] = 1'b1;
    for (int k = 0; k < n; k++) begin
      e = exp_q.pop_front();
      check($sformatf("%s_head%0d", name, k), cmd_data[ch*64 +: 64], e);
      @(posedge aclk);
      #1;
    end
    cmd_ready[ch] = 1'b0;
    check($sformatf("%s_valid_after", name), 64'(cmd_valid[ch]), 64'd0);
  endtask

  localparam logic [63:0] D0 = 64'h5566778811223344;

  initial begin
    rst = 1'b1; reg_en = 1'b0; reg_we = 4'h0; reg_addr = '0; reg_wdata = '0;
    cmd_ready = 2'b00; cmd_done = 2'b00;

    // Vector table: each row is one cycle; expected rdata is the pre-update read of that row.
    vecs.push_back(mk(1, 4'hF, 12'h000, 32'h11223344, 2'b00, 0, 0, 2'b00, 0, 0, 0));
    vecs.push_back(mk(1, 4'hF, 12'h004, 32'h55667788, 2'b00, 0, 0, 2'b01, 0, 1, D0));
    vecs.push_back(mk(1, 4'h0, 12'h008, 32'h0, 2'b00, 1, 32'h00000001, 2'b01, 0, 1, D0));
    vecs.push_back(mk(1, 4'hF, 12'h004, 32'h0000DEAD, 2'b00, 0, 0, 2'b01, 0, 0, 0));
    vecs.push_back(mk(1, 4'h0, 12'h008, 32'h0, 2'b00, 1, 32'h00100001, 2'b01, 0, 0, 0));
    vecs.push_back(mk(1, 4'hF, 12'h008, 32'h00100000, 2'b00, 1, 32'h00100001, 2'b01, 0, 0, 0));
    vecs.push_back(mk(1, 4'h0, 12'h008, 32'h0, 2'b00, 1, 32'h00000001, 2'b01, 0, 0, 0));
    vecs.push_back(mk(1, 4'h3, 12'h000, 32'h0000AAAA, 2'b00, 0, 0, 2'b01, 0, 0, 0));
    vecs.push_back(mk(1, 4'hF, 12'h004, 32'h0000BBBB, 2'b00, 1, 32'h0, 2'b01, 0, 0, 0));
    vecs.push_back(mk(1, 4'h0, 12'h008, 32'h0, 2'b00, 1, 32'h00100001, 2'b01, 0, 1, D0));
    vecs.push_back(mk(1, 4'hF, 12'h008, 32'h00100000, 2'b00, 0, 0, 2'b01, 0, 0, 0));
    vecs.push_back(mk(1, 4'hF, 12'h100, 32'h00000002, 2'b00, 0, 0, 2'b01, 0, 0, 0));
    vecs.push_back(mk(1, 4'h0, 12'h100, 32'h0, 2'b10, 1, 32'h2, 2'b01, 0, 0, 0));
    vecs.push_back(mk(1, 4'h0, 12'h104, 32'h0, 2'b10, 1, 32'h2, 2'b01, 1, 0, 0));
    vecs.push_back(mk(1, 4'h0, 12'h01C, 32'h0, 2'b10, 1, 32'h2, 2'b01, 1, 0, 0));
    vecs.push_back(mk(1, 4'h0, 12'h01C, 32'h0, 2'b00, 1, 32'h3, 2'b01, 1, 0, 0));
    vecs.push_back(mk(1, 4'hF, 12'h104, 32'h2, 2'b10, 1, 32'h2, 2'b01, 1, 0, 0));
    vecs.push_back(mk(1, 4'h0, 12'h104, 32'h0, 2'b00, 1, 32'h2, 2'b01, 1, 0, 0));
    vecs.push_back(mk(1, 4'h0, 12'h01C, 32'h0, 2'b00, 1, 32'h4, 2'b01, 1, 0, 0));
    vecs.push_back(mk(1, 4'hF, 12'h104, 32'h2, 2'b00, 1, 32'h2, 2'b01, 1, 0, 0));
    vecs.push_back(mk(1, 4'h0, 12'h104, 32'h0, 2'b00, 1, 32'h0, 2'b01, 0, 0, 0));
    vecs.push_back(mk(1, 4'hF, 12'h01C, 32'h1234, 2'b10, 1, 32'h4, 2'b01, 0, 0, 0));
    vecs.push_back(mk(1, 4'h0, 12'h01C, 32'h0, 2'b00, 1, 32'h1, 2'b01, 1, 0, 0));
    vecs.push_back(mk(1, 4'hF, 12'h104, 32'h3, 2'b00, 1, 32'h2, 2'b01, 1, 0, 0));
    vecs.push_back(mk(1, 4'h0, 12'h100, 32'h0, 2'b00, 1, 32'h2, 2'b01, 0, 0, 0));
    vecs.push_back(mk(1, 4'h0, 12'h020, 32'h0, 2'b00, 1, 32'h0, 2'b01, 0, 0, 0));
    vecs.push_back(mk(1, 4'h0, 12'h100, 32'h0, 2'b00, 1, 32'h2, 2'b01, 0, 0, 0));
    vecs.push_back(mk(0, 4'h0, 12'h020, 32'h0, 2'b00, 1, 32'h2, 2'b01, 0, 0, 0));
    vecs.push_back(mk(1, 4'h0, 12'h108, 32'h0, 2'b00, 1, 32'h0, 2'b01, 0, 1, D0));

    // Reset state
    repeat (2) @(posedge aclk);
    #1;
    check("reset_rdata", 64'(reg_rdata), 64'd0);
    check("reset_valid", 64'(cmd_valid), 64'd0);
    check("reset_irq", 64'(irq), 64'd0);
    check("reset_data", cmd_data[63:0] | cmd_data[127:64], 64'd0);
    @(negedge aclk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge aclk);
      reg_en = vecs[i].en; reg_we = vecs[i].we; reg_addr = vecs[i].addr;
      reg_wdata = vecs[i].wdata; cmd_ready = vecs[i].rdy; cmd_done = vecs[i].done;
      @(posedge aclk);
      #1;
      if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), 64'(reg_rdata), 64'(vecs[i].exp_rd));
      check($sformatf("vec%0d_valid", i), 64'(cmd_valid), 64'(vecs[i].exp_valid));
      check($sformatf("vec%0d_irq", i), 64'(irq), 64'(vecs[i].exp_irq));
      if (vecs[i].chk_d0) check($sformatf("vec%0d_data0", i), cmd_data[63:0], vecs[i].exp_d0);
    end
    reg_en = 1'b0; reg_we = 4'h0; cmd_done = 2'b00; cmd_ready = 2'b00;

    // Ch1 overflow: nine pushes into an eight-deep queue, then ordered drain.
    exp_q.delete();
    for (int i = 0; i < 9; i++) push_cmd(1, 32'h1000 + i, 32'hA000 + i, i < 8);
    rd_check("ovf_status", 12'h018, 32'h00050008);
    drain(1, 8, "ovf_drain");
    rd_check("ovf_status_empty", 12'h018, 32'h00060000);

    // Ch0: flush leftover, fill, then push into a full queue while the head pops.
    reg_wr(12'h008, 32'h80000000);
    exp_q.delete();
    for (int i = 0; i < 8; i++) push_cmd(0, 32'h2000 + i, 32'hB000 + i, 1'b1);
    rd_check("full_status", 12'h008, 32'h00010008);
    reg_wr(12'h000, 32'h00002ABC);
    check("fullpop_head", cmd_data[63:0], exp_q[0]);
    cmd_ready[0] = 1'b1;
    reg_wr(12'h004, 32'h0000BABC);
    cmd_ready[0] = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back({32'h0000BABC, 32'h00002ABC});
    rd_check("fullpop_status", 12'h008, 32'h00010008);
    drain(0, 8, "fullpop_drain");

    // Flush with five entries and a staged LO while the mover is ready.
    exp_q.delete();
    for (int i = 0; i < 5; i++) push_cmd(0, 32'h3000 + i, 32'hC000 + i, 1'b1);
    reg_wr(12'h000, 32'h00003FFF);
    rd_check("preflush_status", 12'h008, 32'h00080005);
    cmd_ready[0] = 1'b1;
    reg_wr(12'h008, 32'h80000000);
    cmd_ready[0] = 1'b0;
    check("flush_valid", 64'(cmd_valid[0]), 64'd0);
    rd_check("flush_status", 12'h008, 32'h00020000);

    // Reset in the middle of assembling a command with irq raised.
    push_cmd(0, 32'h4000, 32'hD000, 1'b1);
    reg_wr(12'h010, 32'h00005555);
    cmd_done = 2'b10;
    reg_access(4'h0, 12'h100, 32'h0);
    cmd_done = 2'b00;
    rd_check("prerst_irqst", 12'h104, 32'h2);
    check("prerst_irq", 64'(irq), 64'd1);
    @(negedge aclk);
    rst = 1'b1;
    @(posedge aclk);
    #1;
    check("rst_rdata", 64'(reg_rdata), 64'd0);
    check("rst_valid", 64'(cmd_valid), 64'd0);
    check("rst_irq", 64'(irq), 64'd0);
    check("rst_data", cmd_data[63:0] | cmd_data[127:64], 64'd0);
    @(negedge aclk);
    rst = 1'b0;
    rd_check("rst_ch1_status", 12'h018, 32'h00020000);
    rd_check("rst_irq_en", 12'h100, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
